// File: rtl/dma_pkg.sv
// dma_pkg: AHB-Lite encodings, writer FSM states and default widths shared by the DMA destination engine.
package dma_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LEN_W = 16;
   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_WORD = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_FIN, S_ERR} wr_state_t;
endpackage

// File: rtl/dma_byte_packer.sv
// dma_byte_packer: pops FIFO bytes for one beat and places each captured byte in its AHB byte lane.
module dma_byte_packer
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [2:0]  beat_size,
   input  logic [1:0]  lane,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_r_data,
   output logic        fifo_rd,
   output logic        beat_full,
   output logic [31:0] word
);
   logic [2:0] got;
   logic       pend;
   logic [1:0] k;
   always_comb begin
      k = beat_size == 3'd4 ? got[1:0] : lane;
      beat_full = got == beat_size;
      // a pop still in flight counts against the beat so we never over-read
      fifo_rd = en && !fifo_empty && (got + 3'(pend) < beat_size);
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         got <= '0;
         pend <= 1'b0;
         word <= '0;
      end else begin
         pend <= fifo_rd;
         if (pend) begin
            word[{k, 3'b000} +: 8] <= fifo_r_data;
            got <= got + 3'd1;
         end
      end
   end
endmodule

// File: rtl/dma_fifo_ahb_writer.sv
// dma_fifo_ahb_writer: drains the DMA byte FIFO into AHB-Lite single writes at an incrementing address.
module dma_fifo_ahb_writer
   import dma_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  byte_len,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              fifo_rd,
   input  logic              fifo_empty,
   input  logic [7:0]        fifo_r_data,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [31:0]       hwdata,
   input  logic              hready,
   input  logic              hresp
);
   wr_state_t         state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [2:0]        beat_size;
   logic              beat_full, accept, xfer_ok, xfer_err;
   always_comb begin
      // tails shorter than a word go out one byte at a time
      beat_size = remaining >= LEN_W'(4) ? 3'd4 : 3'd1;
      accept = state == S_IDLE && start;
      xfer_ok = state == S_DATA && hready && !hresp;
      xfer_err = state == S_DATA && hready && hresp;
      state_nx = S_IDLE;
      case (state)
         S_IDLE: state_nx = !start ? S_IDLE : byte_len == '0 ? S_FIN : S_FILL;
         S_FILL: state_nx = beat_full ? S_ADDR : S_FILL;
         S_ADDR: state_nx = hready ? S_DATA : S_ADDR;
         S_DATA: state_nx = !hready ? S_DATA : hresp ? S_ERR : remaining == LEN_W'(beat_size) ? S_FIN : S_FILL;
         default: state_nx = S_IDLE;
      endcase
      busy = state inside {S_FILL, S_ADDR, S_DATA};
      done = state inside {S_FIN, S_ERR};
      htrans = state == S_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
      hwrite = state == S_ADDR;
      hsize = beat_size == 3'd4 ? HSIZE_WORD : HSIZE_BYTE;
      hburst = HBURST_SINGLE;
      haddr = addr;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         addr <= '0;
         remaining <= '0;
         error <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr <= dst_addr;
            remaining <= byte_len;
            error <= 1'b0;
         end
         if (xfer_ok) begin
            addr <= addr + ADDR_W'(beat_size);
            remaining <= remaining - LEN_W'(beat_size);
         end
         if (xfer_err) error <= 1'b1;
      end
   end
   dma_byte_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .clr         (state == S_IDLE || xfer_ok),
      .en          (state == S_FILL),
      .beat_size   (beat_size),
      .lane        (addr[1:0]),
      .fifo_empty  (fifo_empty),
      .fifo_r_data (fifo_r_data),
      .fifo_rd     (fifo_rd),
      .beat_full   (beat_full),
      .word        (hwdata)
   );
endmodule

// File: doc/dma_fifo_ahb_writer.md
Name: dma_fifo_ahb_writer

Overview:
Read-side consumer of the DMA byte FIFO: drains 8-bit entries through the FIFO's rd/empty/r_data interface.
- Packs bytes little-endian into 32-bit words and issues AHB-Lite single write transfers to an incrementing destination address.
- Sits between the channel FIFO and the AHB master port as the DMA destination engine.
- One transfer per start command; reports busy/done/error to the channel controller.

Parameters:
ADDR_W, 32, AHB address width
LEN_W, 16, width of byte-length field (max transfer 2^LEN_W-1 bytes)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle command pulse; sampled only when busy=0
dst_addr  in  ADDR_W  destination byte address, word-aligned (dst_addr[1:0]=0 required)
byte_len  in  LEN_W  bytes to move
busy  out  1  command in progress
done  out  1  one-cycle completion pulse (normal or error)
error  out  1  sticky AHB error flag, cleared by next accepted start
fifo_rd  out  1  FIFO pop strobe
fifo_empty  in  1  FIFO empty
fifo_r_data  in  8  FIFO read data, valid the cycle after fifo_rd
haddr  out  ADDR_W  AHB address
htrans  out  2  AHB transfer type (IDLE=00, NONSEQ=10 only)
hwrite  out  1  AHB write
hsize  out  3  000 byte, 010 word
hburst  out  3  constant 000 (SINGLE)
hwdata  out  32  AHB write data
hready  in  1  AHB ready
hresp  in  1  AHB response (1=ERROR)

Behaviour:
- Reset (sync, rst=1 at edge): busy, done, error, fifo_rd, hwrite = 0; htrans=IDLE; haddr, hsize, hwdata = 0. FSM goes to IDLE. Packed bytes and counters are discarded. Reset mid-transfer aborts with no done pulse.
- FSM: IDLE -> FILL -> ADDR -> DATA -> (FILL | FIN | ERR) -> IDLE.
- IDLE: on start, latch dst_addr and byte_len into addr/remaining; clear error; busy=1.
  - byte_len=0: go to FIN; no FIFO pops, no AHB transfers.
- FILL: beat size = 4 if remaining>=4, else 1 (tail bytes go out as single byte writes).
  - fifo_rd=1 only when !fifo_empty and requested-but-uncaptured + captured < beat size. Back-to-back pops are allowed.
  - fifo_r_data is captured one cycle after each pop into lane k = byte index within the beat (word beat) or addr[1:0] (byte beat).
  - When the beat is complete, go to ADDR.
- ADDR: drive htrans=NONSEQ, hwrite=1, haddr=addr, hsize per beat. Hold all of these until hready=1, then go to DATA.
- DATA: htrans=IDLE; hwdata held stable until hready=1.
  - hready=1, hresp=0: addr += beat, remaining -= beat. Go to FIN if remaining=0, else FILL.
  - hready=1, hresp=1: go to ERR.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- ERR: error=1 (sticky), done=1 for one cycle, busy=0, go to IDLE. No further pops; bytes already in the FIFO are left for channel flush.
- start while busy=1 is ignored.
- No overlap of address and data phases: at most one outstanding AHB transfer.
- FIFO empty in FILL: stall indefinitely, fifo_rd=0, htrans=IDLE.
- Byte-lane rule for tail writes: hwdata[8*a+7:8*a] carries the byte, where a=addr[1:0]; other lanes are 0.
- Address wraps modulo 2^ADDR_W; no 1 KB boundary check is needed for single transfers.

Decomposition:
- Shared package/include dma_pkg:
  - HTRANS_IDLE/NONSEQ, HSIZE_BYTE/WORD, HBURST_SINGLE
  - FSM state encodings
  - default ADDR_W/LEN_W
- One natural sub-module: dma_byte_packer. It owns the pop-request counter, the pending-capture flag and the lane placement, exposing beat_size in and beat_full/word out. The top level keeps the FSM, counters and AHB drive.

Test Plan:
1. FIFO preloaded 01..08, start dst=0x2000_0000 len=8, hready=1 -> 8 fifo_rd pulses; word writes 0x2000_0000/0x04030201 and 0x2000_0004/0x08070605; done 1 cycle; busy=0 after.
2. FIFO preloaded 01..06, len=6 -> word write 0x2000_0000/0x04030201; byte write 0x2000_0004 hwdata=0x00000005; byte write 0x2000_0005 hwdata=0x00000600; hsize 010, 000, 000.
3. FIFO refilled one byte every 5 cycles, len=4 -> fifo_rd never high while fifo_empty=1; htrans stays IDLE until the 4th byte is captured; single write 0x04030201.
4. hready=0 for 3 cycles in both ADDR and DATA -> haddr, htrans=NONSEQ and hwdata held stable across waits; next beat's addr = prior+4.
5. hresp=1 on first beat of len=8 -> error=1, done pulse, at most 4 fifo_rd total, no second NONSEQ. A following start with len=0 clears error and gives done one cycle after start.
6. rst=1 in FILL after 2 pops -> next cycle busy=0, fifo_rd=0, htrans=IDLE, hwdata=0. A new start len=4 then writes a fresh word built from the next 4 FIFO bytes.
